// File: rtl/pixel_row_packer.sv
// pixel_row_packer
//
// Transmit side of the line-buffer row interface. Pixels arrive one per beat
// under a valid/ready handshake and are packed, pixel 0 at the LSB, into a
// wide word holding K image rows of W pixels. A full assembly word moves to
// a skid register. From there it is emitted as a single-cycle valid pulse
// toward the 3-row line buffer whenever the downstream side is ready. Each
// emitted word is counted, and frame_done_o flags the H-th word of a frame.
//
// Optional feature (macro PIXEL_ROW_PACKER_FLUSH_EN): adds flush_i. A flush
// closes a partially filled word early. The unfilled pixel positions are
// zero-filled and the word is queued for emission as if it were full.
//
// Ports:
//   clk          in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   flush_i      in   (PIXEL_ROW_PACKER_FLUSH_EN only) close partial word
//   pix_i        in   D*DATA_BITS pixel data
//   pix_valid_i  in   pix_i valid
//   pix_ready_o  out  packer can accept a pixel this cycle
//   row_data_o   out  D*W*DATA_BITS*K packed row word, held between pulses
//   row_valid_o  out  one-cycle pulse marking a new row_data_o
//   row_ready_i  in   downstream may take a row word (level)
//   frame_done_o out  pulse coincident with the H-th row_valid_o of a frame

`timescale 1ns/1ps

module pixel_row_packer #(
    parameter int DATA_BITS = 8,
    parameter int D         = 1,
    parameter int W         = 12,
    parameter int K         = 2,
    parameter int H         = 3
) (
    input  logic                           clk,
    input  logic                           resetn,
`ifdef PIXEL_ROW_PACKER_FLUSH_EN
    input  logic                           flush_i,
`endif
    input  logic [D*DATA_BITS-1:0]         pix_i,
    input  logic                           pix_valid_i,
    output logic                           pix_ready_o,
    output logic [D*W*DATA_BITS*K-1:0]     row_data_o,
    output logic                           row_valid_o,
    input  logic                           row_ready_i,
    output logic                           frame_done_o
);

    localparam int PIX_BITS  = D * DATA_BITS;
    localparam int ROW_BITS  = D * W * DATA_BITS * K;
    localparam int NPIX      = K * W;
    localparam int CNT_W     = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int ROW_CNT_W = (H > 1) ? $clog2(H) : 1;

    localparam logic [CNT_W-1:0]     PIX_LAST = CNT_W'(NPIX - 1);
    localparam logic [ROW_CNT_W-1:0] ROW_LAST = ROW_CNT_W'(H - 1);

    logic [ROW_BITS-1:0]  asm_q, asm_d;
    logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic                 asm_full_q, asm_full_d;
    logic [ROW_BITS-1:0]  skid_q, skid_d;
    logic                 skid_full_q, skid_full_d;
    logic [ROW_BITS-1:0]  row_data_q, row_data_d;
    logic                 row_valid_q, row_valid_d;
    logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic                 frame_done_q, frame_done_d;

    logic accept;
    logic emit;
    logic xfer;

`ifdef PIXEL_ROW_PACKER_FLUSH_EN
    int fill_start;
`endif

    // Ready depends only on registered state, never on pix_valid_i.
    assign pix_ready_o = !asm_full_q;
    assign accept      = pix_valid_i && pix_ready_o;

    // Emission requires row_valid_q low, so pulses are always separated by
    // at least one idle cycle.
    assign emit = skid_full_q && row_ready_i && !row_valid_q;

    // The skid register can take the assembly word if it is empty, or if it
    // is being emptied by an emission on this same edge.
    assign xfer = asm_full_q && (!skid_full_q || emit);

    always_comb begin
        asm_d        = asm_q;
        pix_cnt_d    = pix_cnt_q;
        asm_full_d   = asm_full_q;
        skid_d       = skid_q;
        skid_full_d  = skid_full_q;
        row_data_d   = row_data_q;
        row_valid_d  = 1'b0;
        row_cnt_d    = row_cnt_q;
        frame_done_d = 1'b0;
`ifdef PIXEL_ROW_PACKER_FLUSH_EN
        fill_start   = 0;
`endif

        if (accept) begin
            for (int p = 0; p < NPIX; p++) begin
                if (pix_cnt_q == CNT_W'(p)) begin
                    asm_d[p*PIX_BITS +: PIX_BITS] = pix_i;
                end
            end
            if (pix_cnt_q == PIX_LAST) begin
                pix_cnt_d  = '0;
                asm_full_d = 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end

`ifdef PIXEL_ROW_PACKER_FLUSH_EN
        // A pixel accepted on the flush edge keeps its slot, so zero-fill
        // begins one position later in that case.
        if (flush_i && !asm_full_q && (pix_cnt_q != '0)) begin
            fill_start = int'(pix_cnt_q) + (accept ? 1 : 0);
            for (int p = 0; p < NPIX; p++) begin
                if (p >= fill_start) begin
                    asm_d[p*PIX_BITS +: PIX_BITS] = '0;
                end
            end
            asm_full_d = 1'b1;
            pix_cnt_d  = '0;
        end
`endif

        if (emit) begin
            row_data_d  = skid_q;
            row_valid_d = 1'b1;
            skid_full_d = 1'b0;
            if (row_cnt_q == ROW_LAST) begin
                row_cnt_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
            end
        end

        // Evaluated after emit, so a same-edge refill leaves the skid full.
        if (xfer) begin
            skid_d      = asm_q;
            skid_full_d = 1'b1;
            asm_full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            asm_q        <= '0;
            pix_cnt_q    <= '0;
            asm_full_q   <= 1'b0;
            skid_q       <= '0;
            skid_full_q  <= 1'b0;
            row_data_q   <= '0;
            row_valid_q  <= 1'b0;
            row_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            pix_cnt_q    <= pix_cnt_d;
            asm_full_q   <= asm_full_d;
            skid_q       <= skid_d;
            skid_full_q  <= skid_full_d;
            row_data_q   <= row_data_d;
            row_valid_q  <= row_valid_d;
            row_cnt_q    <= row_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_data_o   = row_data_q;
    assign row_valid_o  = row_valid_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_pixel_row_packer.sv
// tb_pixel_row_packer
//
// Directed testbench for pixel_row_packer with default parameters
// (8-bit mono pixels, 12 pixels per row, 2 rows per word, 3 words per frame).
// Flush scenarios are built only when PIXEL_ROW_PACKER_FLUSH_EN is defined.

`timescale 1ns/1ps

module tb_pixel_row_packer;

    localparam int ROW_BITS = 192;

    logic                clk;
    logic                resetn;
`ifdef PIXEL_ROW_PACKER_FLUSH_EN
    logic                flush_i;
`endif
    logic [7:0]          pix_i;
    logic                pix_valid_i;
    logic                pix_ready_o;
    logic [ROW_BITS-1:0] row_data_o;
    logic                row_valid_o;
    logic                row_ready_i;
    logic                frame_done_o;

    int n_assert;
    int n_fail;

    // Every emitted word is logged by the monitor, along with the
    // frame_done_o value seen in the same cycle.
    logic [ROW_BITS-1:0] words[$];
    bit                  fd_flags[$];
    int                  fd_total;
    int                  adjacent;
    logic                prev_valid;

    pixel_row_packer dut (
        .clk          (clk),
        .resetn       (resetn),
`ifdef PIXEL_ROW_PACKER_FLUSH_EN
        .flush_i      (flush_i),
`endif
        .pix_i        (pix_i),
        .pix_valid_i  (pix_valid_i),
        .pix_ready_o  (pix_ready_o),
        .row_data_o   (row_data_o),
        .row_valid_o  (row_valid_o),
        .row_ready_i  (row_ready_i),
        .frame_done_o (frame_done_o)
    );

    // 10 ns clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The monitor samples on the falling edge, halfway between active edges.
    always @(negedge clk) begin
        if (resetn) begin
            if (row_valid_o) begin
                words.push_back(row_data_o);
                fd_flags.push_back(frame_done_o);
                if (prev_valid === 1'b1) adjacent <= adjacent + 1;
            end
            if (frame_done_o) fd_total <= fd_total + 1;
            prev_valid <= row_valid_o;
        end
    end

    // Builds a word whose byte i equals first + i*step.
    function automatic logic [ROW_BITS-1:0] seq_word(input int first, input int step);
        logic [ROW_BITS-1:0] w;
        w = '0;
        for (int i = 0; i < 24; i++) w[i*8 +: 8] = 8'(first + i * step);
        return w;
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the pixel valid until it is accepted; the bench returns 1 ns
    // after the accepting edge with pix_valid_i still high.
    task automatic send_pixel(input logic [7:0] v);
        int   waited;
        logic rdy;
        waited      = 0;
        pix_i       = v;
        pix_valid_i = 1'b1;
        do begin
            rdy = pix_ready_o;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 200);
        if (!rdy) begin
            n_fail++;
            $display("[TB] FAIL send_timeout: pixel %h not accepted, ready=%b required 1", v, pix_ready_o);
        end
        n_assert++;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        resetn      = 1'b0;
        pix_valid_i = 1'b0;
`ifdef PIXEL_ROW_PACKER_FLUSH_EN
        flush_i     = 1'b0;
`endif
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        if (pix_ready_o !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_ready: got %b required 1", pix_ready_o);
        end
        n_assert++;
        if (row_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_valid: got %b required 0", row_valid_o);
        end
        n_assert++;
        if (row_data_o !== '0) begin
            n_fail++; $display("[TB] FAIL reset_data: got %h required 0", row_data_o);
        end
        n_assert++;
        if (frame_done_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_frame_done: got %b required 0", frame_done_o);
        end
        n_assert++;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_single_row();
        logic [ROW_BITS-1:0] exp;
        reset_dut();
        row_ready_i = 1'b1;
        exp = seq_word(1, 1);
        for (int i = 0; i < 24; i++) send_pixel(8'(i + 1));
        pix_valid_i = 1'b0;
        if (row_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_early0: valid %b required 0", row_valid_o);
        end
        n_assert++;
        wait_cycles(1);
        if (row_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_early1: valid %b required 0", row_valid_o);
        end
        n_assert++;
        wait_cycles(1);
        if (row_valid_o !== 1'b1) begin
            n_fail++; $display("[TB] FAIL single_valid: valid %b required 1", row_valid_o);
        end
        n_assert++;
        if (row_data_o[7:0] !== 8'h01) begin
            n_fail++; $display("[TB] FAIL single_byte0: got %h required 01", row_data_o[7:0]);
        end
        n_assert++;
        if (row_data_o[191:184] !== 8'h18) begin
            n_fail++; $display("[TB] FAIL single_byte23: got %h required 18", row_data_o[191:184]);
        end
        n_assert++;
        if (row_data_o !== exp) begin
            n_fail++; $display("[TB] FAIL single_word: got %h required %h", row_data_o, exp);
        end
        n_assert++;
        if (frame_done_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_frame_done: got %b required 0", frame_done_o);
        end
        n_assert++;
        wait_cycles(1);
        if (row_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_pulse_width: valid %b required 0", row_valid_o);
        end
        n_assert++;
        if (row_data_o !== exp) begin
            n_fail++; $display("[TB] FAIL single_hold: got %h required %h", row_data_o, exp);
        end
        n_assert++;
    endtask

    task automatic test_frame();
        int base;
        int fd_base;
        int adj_base;
        reset_dut();
        row_ready_i = 1'b1;
        base     = words.size();
        fd_base  = fd_total;
        adj_base = adjacent;
        for (int i = 0; i < 72; i++) send_pixel(8'(i * 3 + 1));
        pix_valid_i = 1'b0;
        wait_cycles(5);
        if (words.size() - base !== 3) begin
            n_fail++; $display("[TB] FAIL frame_pulses: got %0d required 3", words.size() - base);
        end
        n_assert++;
        for (int r = 0; r < 3; r++) begin
            if (words[base + r] !== seq_word(r * 72 + 1, 3)) begin
                n_fail++; $display("[TB] FAIL frame_word%0d: got %h required %h", r, words[base + r], seq_word(r * 72 + 1, 3));
            end
            n_assert++;
            if (fd_flags[base + r] !== (r == 2)) begin
                n_fail++; $display("[TB] FAIL frame_done_at%0d: got %b required %b", r, fd_flags[base + r], (r == 2));
            end
            n_assert++;
        end
        if (fd_total - fd_base !== 1) begin
            n_fail++; $display("[TB] FAIL frame_done_count: got %0d required 1", fd_total - fd_base);
        end
        n_assert++;
        if (adjacent - adj_base !== 0) begin
            n_fail++; $display("[TB] FAIL frame_adjacent: got %0d required 0", adjacent - adj_base);
        end
        n_assert++;
        if (dut.row_cnt_q !== '0) begin
            n_fail++; $display("[TB] FAIL frame_row_cnt: got %0d required 0", dut.row_cnt_q);
        end
        n_assert++;
    endtask

    task automatic test_backpressure();
        int base;
        reset_dut();
        row_ready_i = 1'b0;
        base = words.size();
        for (int i = 0; i < 48; i++) send_pixel(8'(i + 1));
        pix_i       = 8'd49;
        pix_valid_i = 1'b1;
        if (pix_ready_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp_ready_low: got %b required 0", pix_ready_o);
        end
        n_assert++;
        wait_cycles(5);
        if (pix_ready_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp_ready_held: got %b required 0", pix_ready_o);
        end
        n_assert++;
        if (words.size() - base !== 0) begin
            n_fail++; $display("[TB] FAIL bp_no_pulse: got %0d pulses required 0", words.size() - base);
        end
        n_assert++;
        if (dut.pix_cnt_q !== '0) begin
            n_fail++; $display("[TB] FAIL bp_ignored: pix_cnt %0d required 0", dut.pix_cnt_q);
        end
        n_assert++;
        row_ready_i = 1'b1;
        for (int i = 48; i < 60; i++) send_pixel(8'(i + 1));
        pix_valid_i = 1'b0;
        wait_cycles(6);
        if (words.size() - base !== 2) begin
            n_fail++; $display("[TB] FAIL bp_pulses: got %0d required 2", words.size() - base);
        end
        n_assert++;
        if (words[base] !== seq_word(1, 1)) begin
            n_fail++; $display("[TB] FAIL bp_word1: got %h required %h", words[base], seq_word(1, 1));
        end
        n_assert++;
        if (words[base + 1] !== seq_word(25, 1)) begin
            n_fail++; $display("[TB] FAIL bp_word2: got %h required %h", words[base + 1], seq_word(25, 1));
        end
        n_assert++;
        if (dut.pix_cnt_q !== 5'd12) begin
            n_fail++; $display("[TB] FAIL bp_remaining: pix_cnt %0d required 12", dut.pix_cnt_q);
        end
        n_assert++;
        if (pix_ready_o !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bp_ready_after: got %b required 1", pix_ready_o);
        end
        n_assert++;
    endtask

    task automatic test_reset_mid();
        int base;
        reset_dut();
        row_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) send_pixel(8'h55);
        pix_valid_i = 1'b0;
        resetn      = 1'b0;
        #1;
        if (dut.pix_cnt_q !== '0) begin
            n_fail++; $display("[TB] FAIL mid_reset_cnt: got %0d required 0", dut.pix_cnt_q);
        end
        n_assert++;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        base = words.size();
        for (int i = 0; i < 24; i++) send_pixel(8'(8'hA0 + i));
        pix_valid_i = 1'b0;
        wait_cycles(6);
        if (words.size() - base !== 1) begin
            n_fail++; $display("[TB] FAIL mid_pulses: got %0d required 1", words.size() - base);
        end
        n_assert++;
        if (words[base] !== seq_word(8'hA0, 1)) begin
            n_fail++; $display("[TB] FAIL mid_word: got %h required %h", words[base], seq_word(8'hA0, 1));
        end
        n_assert++;
        if (fd_flags[base] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_frame_done: got %b required 0", fd_flags[base]);
        end
        n_assert++;
    endtask

`ifdef PIXEL_ROW_PACKER_FLUSH_EN
    task automatic test_flush();
        int                  base;
        logic [ROW_BITS-1:0] exp;
        reset_dut();
        row_ready_i = 1'b1;
        for (int i = 0; i < 24; i++) send_pixel(8'hFF);
        for (int i = 0; i < 5; i++) send_pixel(8'(8'h11 + i));
        pix_valid_i = 1'b0;
        wait_cycles(4);
        base    = words.size();
        flush_i = 1'b1;
        wait_cycles(1);
        flush_i = 1'b0;
        wait_cycles(5);
        exp = '0;
        for (int i = 0; i < 5; i++) exp[i*8 +: 8] = 8'(8'h11 + i);
        if (words.size() - base !== 1) begin
            n_fail++; $display("[TB] FAIL flush_pulses: got %0d required 1", words.size() - base);
        end
        n_assert++;
        if (words[base] !== exp) begin
            n_fail++; $display("[TB] FAIL flush_word: got %h required %h", words[base], exp);
        end
        n_assert++;
    endtask

    task automatic test_flush_empty();
        int base;
        base    = words.size();
        flush_i = 1'b1;
        wait_cycles(1);
        flush_i = 1'b0;
        wait_cycles(5);
        if (words.size() - base !== 0) begin
            n_fail++; $display("[TB] FAIL flush_empty_pulses: got %0d required 0", words.size() - base);
        end
        n_assert++;
        if (pix_ready_o !== 1'b1) begin
            n_fail++; $display("[TB] FAIL flush_empty_ready: got %b required 1", pix_ready_o);
        end
        n_assert++;
        if (dut.pix_cnt_q !== '0) begin
            n_fail++; $display("[TB] FAIL flush_empty_cnt: got %0d required 0", dut.pix_cnt_q);
        end
        n_assert++;
    endtask
`endif

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        resetn      = 1'b0;
        pix_i       = '0;
        pix_valid_i = 1'b0;
        row_ready_i = 1'b0;
`ifdef PIXEL_ROW_PACKER_FLUSH_EN
        flush_i     = 1'b0;
`endif
        $display("[TB] starting pixel_row_packer tests");
        test_reset();
        test_single_row();
        test_frame();
        test_backpressure();
        test_reset_mid();
`ifdef PIXEL_ROW_PACKER_FLUSH_EN
        test_flush();
        test_flush_empty();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_row_packer.md
Name: pixel_row_packer

Overview:
- Transmit side of the line-buffer row interface.
- Accepts a pixel stream, one D-channel pixel per beat, under a valid/ready handshake.
- Packs K consecutive image rows of W pixels into one wide row word, then emits that word as a single-cycle valid pulse to the 3-row line buffer.
- Two-stage buffering (assembly + skid) lets pixel intake overlap with the wait for downstream readiness. Counts emitted row words per frame of H.

Parameters:
- DATA_BITS, 8, bits per channel sample
- D, 1, channels per pixel
- W, 12, pixels per image row (unpadded)
- K, 2, image rows packed per emitted row word
- H, 3, row words per frame

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  reset, asynchronous, active-low
- pix_i  input  D*DATA_BITS  pixel data
- pix_valid_i  input  1  pix_i valid
- pix_ready_o  output  1  packer can accept a pixel this cycle
- row_data_o  output  D*W*DATA_BITS*K  packed row word; stable between emissions
- row_valid_o  output  1  one-cycle pulse: row_data_o is new (drives line-buffer valid_i)
- row_ready_i  input  1  downstream may take a row word (level)
- frame_done_o  output  1  one-cycle pulse coincident with the H-th row_valid_o of a frame

Behaviour:
- Registers:
  - asm: assembly buffer, width D*W*DATA_BITS*K.
  - pix_cnt: 0..K*W-1.
  - asm_full.
  - skid: width D*W*DATA_BITS*K.
  - skid_full.
  - row_data_o, row_valid_o.
  - row_cnt: 0..H-1.
  - frame_done_o.
- Reset values: all registers 0, so row_data_o=0, row_valid_o=0, frame_done_o=0, pix_ready_o=1.
- pix_ready_o = !asm_full (decoded from register, no path from pix_valid_i).
- Accept: on an edge with pix_valid_i & pix_ready_o:
  - asm[pix_cnt*D*DATA_BITS +: D*DATA_BITS] <= pix_i. Pixel 0 is at the LSB; image row j occupies slice [D*W*DATA_BITS*j +: D*W*DATA_BITS].
  - If pix_cnt==K*W-1: pix_cnt<=0 and asm_full<=1. Otherwise pix_cnt increments.
- Emit: on an edge with skid_full & row_ready_i & !row_valid_o:
  - row_data_o<=skid, row_valid_o<=1, skid_full<=0.
  - row_valid_o is forced to 0 on the next edge, so it is always a single-cycle pulse and back-to-back pulses are impossible (minimum spacing 2 cycles).
- Transfer: on an edge with asm_full & (!skid_full | emit):
  - skid<=asm, skid_full<=1, asm_full<=0.
  - Emit and transfer on the same edge is legal. row_data_o takes the old skid contents and skid takes asm.
- Latency: with row_ready_i held high, last pixel accepted on edge E0, transfer on E1, row_valid_o high in the cycle after E2.
- Frame counting: each emit increments row_cnt. If row_cnt==H-1, row_cnt<=0 and frame_done_o<=1 (same edge as row_valid_o). Otherwise frame_done_o<=0.
- Full backpressure: asm_full & skid_full & !row_ready_i leaves pix_ready_o=0 indefinitely. No data is lost or overwritten.
- row_ready_i drops while skid_full: emission waits; row_data_o holds its last value.
- pix_valid_i high while pix_ready_o low: ignored, no state change.
- Reset mid-operation: partial asm contents discarded, pix_cnt=0, skid cleared, row_cnt=0. The first pixel after reset is pixel 0 of a new frame.

Optional Feature:
- Macro: PIXEL_ROW_PACKER_FLUSH_EN.
- Defined:
  - Adds input port flush_i, 1 bit.
  - On an edge with flush_i & !asm_full & pix_cnt!=0: all positions >= pix_cnt are zero-filled, asm_full<=1, pix_cnt<=0.
  - A pixel accepted on that same edge is written first at pix_cnt and zero-fill starts at pix_cnt+1.
  - flush_i with pix_cnt==0 or asm_full=1: no effect.
- Not defined: no flush_i port; a row word is emitted only after exactly K*W pixels.

Test Plan:
- Defaults, row_ready_i=1, feed 24 pixels 0x01..0x18 back-to-back.
  -> One row_valid_o pulse 2 cycles after the last accept; row_data_o[7:0]=0x01, row_data_o[191:184]=0x18; frame_done_o=0.
- Feed 72 pixels continuously, row_ready_i=1.
  -> Exactly 3 row_valid_o pulses; frame_done_o pulses with the 3rd only; row_cnt back to 0.
- row_ready_i=0, feed 60 pixels.
  -> pix_ready_o falls after pixel 48 (asm and skid full); row_valid_o stays 0.
  -> Raise row_ready_i: pulses carry words 1 then 2 in order; remaining 12 pixels are then accepted.
- Assert resetn=0 after 10 pixels, release, feed 24 pixels 0xA0.. .
  -> Emitted word contains only 0xA0..0xB7; no stale data.
- With PIXEL_ROW_PACKER_FLUSH_EN: feed 5 pixels, then pulse flush_i.
  -> row_valid_o pulse; bytes 0..4 = the pixels, bytes 5..23 = 0x00.
- With PIXEL_ROW_PACKER_FLUSH_EN: flush_i with pix_cnt==0.
  -> No pulse, no state change.
